// File: rtl/bcd_serial_alu_ctrl.sv
// Digit-serial BCD add/subtract controller that time-shares one 4-bit binary adder.
// Optional feature macro: BCD_SUB_EN (enables the subtract path selected by op).

module four_bit_add (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  assign {cout, sum} = 5'(x) + 5'(y) + 5'(cin);
endmodule

module bcd_serial_alu_ctrl #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                op,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] result,
  output logic                cout,
  output logic                bcd_err,
  output logic [1:0]          dbg_state
);
  localparam int W = 4 * DIGITS;
  localparam logic [3:0] LAST = 4'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    CORR = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [W-1:0] a_r, b_r, res_int, res_nxt;
  logic [3:0]   idx;
  logic         carry, err_r;
  logic [4:0]   raw;
  logic [3:0]   a_d, b_d, b_eff;
  logic [3:0]   add_x, add_y, add_sum;
  logic         add_cin, add_cout;
  logic         raw_gt9;
  logic [3:0]   digit_nxt;
  logic         in_err;

`ifdef BCD_SUB_EN
  logic op_r;
`else
  logic unused_op;
  assign unused_op = op;
`endif

  // The only arithmetic unit: digit sum in ADD, +6 correction in CORR.
  four_bit_add u_add (
    .x   (add_x),
    .y   (add_y),
    .cin (add_cin),
    .sum (add_sum),
    .cout(add_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ADD;
      ADD:     state_nxt = CORR;
      CORR:    state_nxt = (idx == LAST) ? DONE : ADD;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == ADD) || (state == CORR);
    done      = (state == DONE);
    dbg_state = state;
    if (state == CORR) begin
      add_x   = raw[3:0];
      add_y   = 4'd6;
      add_cin = 1'b0;
    end else begin
      add_x   = a_d;
      add_y   = b_eff;
      add_cin = carry;
    end
  end

  always_comb begin
    a_d = 4'd0;
    b_d = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == 4'(i)) begin
        a_d = a_r[i*4 +: 4];
        b_d = b_r[i*4 +: 4];
      end
    end
  end

`ifdef BCD_SUB_EN
  // Nine's complement of b; with carry-in 1 this forms the ten's complement.
  assign b_eff = op_r ? (4'd9 - b_d) : b_d;
`else
  assign b_eff = b_d;
`endif

  always_comb begin
    in_err = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if ((a[i*4 +: 4] > 4'd9) || (b[i*4 +: 4] > 4'd9)) in_err = 1'b1;
    end
  end

  assign raw_gt9   = (raw > 5'd9);
  assign digit_nxt = raw_gt9 ? add_sum : raw[3:0];

  always_comb begin
    res_nxt = res_int;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == 4'(i)) res_nxt[i*4 +: 4] = digit_nxt;
    end
  end

  // Outputs load on the edge entering DONE so they are already valid while done is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r     <= '0;
      b_r     <= '0;
      res_int <= '0;
      idx     <= 4'd0;
      carry   <= 1'b0;
      err_r   <= 1'b0;
      raw     <= 5'd0;
      result  <= '0;
      cout    <= 1'b0;
      bcd_err <= 1'b0;
`ifdef BCD_SUB_EN
      op_r    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_r     <= a;
            b_r     <= b;
            res_int <= '0;
            idx     <= 4'd0;
            err_r   <= in_err;
`ifdef BCD_SUB_EN
            op_r    <= op;
            carry   <= op;
`else
            carry   <= 1'b0;
`endif
          end
        end
        ADD: raw <= {add_cout, add_sum};
        CORR: begin
          res_int <= res_nxt;
          carry   <= raw_gt9;
          if (idx == LAST) begin
            result  <= res_nxt;
            cout    <= raw_gt9;
            bcd_err <= err_r;
          end else begin
            idx <= idx + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_serial_alu_ctrl.sv
// Randomized self-checking bench for bcd_serial_alu_ctrl against a decimal-arithmetic model.
module tb_bcd_serial_alu_ctrl;
  localparam int D = 4;
  localparam int W = 4 * D;

  logic         clk = 1'b0;
  logic         rst, start, op;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W-1:0] result;
  logic         cout, bcd_err;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W+1:0] exp_q[$];
  logic [W-1:0] last_result = '0;

  bcd_serial_alu_ctrl #(.DIGITS(D)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .bcd_err  (bcd_err),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns {bcd_err, cout, result}. Valid BCD uses integer arithmetic; invalid digits
  // follow the per-digit add-then-correct rule.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic sub);
    longint xa = 0, yb = 0, m = 1, r;
    logic bad = 1'b0;
    logic [W-1:0] res = '0;
    logic c;
    int xd, yd, s;
    for (int i = D - 1; i >= 0; i--) begin
      xd = int'(x[i*4 +: 4]);
      yd = int'(y[i*4 +: 4]);
      if (xd > 9 || yd > 9) bad = 1'b1;
      xa = xa * 10 + longint'(xd);
      yb = yb * 10 + longint'(yd);
      m  = m * 10;
    end
    if (!bad) begin
      if (sub) begin
        r = xa - yb + m;
        c = (xa >= yb);
      end else begin
        r = xa + yb;
        c = (r >= m);
      end
      r = r % m;
      for (int i = 0; i < D; i++) begin
        res[i*4 +: 4] = 4'(r % 10);
        r = r / 10;
      end
    end else begin
      c = sub;
      for (int i = 0; i < D; i++) begin
        xd = int'(x[i*4 +: 4]);
        yd = int'(y[i*4 +: 4]);
        s  = xd + (sub ? ((9 - yd) & 15) : yd) + int'(c);
        if (s > 9) begin
          res[i*4 +: 4] = 4'((s + 6) & 15);
          c = 1'b1;
        end else begin
          res[i*4 +: 4] = 4'(s);
          c = 1'b0;
        end
      end
    end
    return {bad, c, res};
  endfunction

  function automatic logic eff_op(input logic o);
`ifdef BCD_SUB_EN
    return o;
`else
    return 1'b0 & o;
`endif
  endfunction

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic o, input logic inject, input logic [W+1:0] expv);
    int cyc;
    logic busy_ok, held_ok;
    logic [W+1:0] e;
    exp_q.push_back(expv);
    @(negedge clk);
    start = 1'b1; a = x; b = y; op = o;
    @(negedge clk);
    start = 1'b0; a = W'($urandom); b = W'($urandom); op = 1'($urandom);
    cyc = 1; busy_ok = 1'b1; held_ok = 1'b1;
    while (!done && cyc <= 40) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (result !== last_result) held_ok = 1'b0;
      if (inject && (cyc == 3 || cyc == 5)) begin
        start = 1'b1; a = W'($urandom); b = W'($urandom); op = 1'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    e = exp_q.pop_front();
    check({tag, ".latency"}, 64'(cyc), 64'(2 * D + 1));
    check({tag, ".busy_during"}, 64'(busy_ok), 64'd1);
    check({tag, ".result_held"}, 64'(held_ok), 64'd1);
    check({tag, ".result"}, 64'(result), 64'(e[W-1:0]));
    check({tag, ".cout"}, 64'(cout), 64'(e[W]));
    check({tag, ".bcd_err"}, 64'(bcd_err), 64'(e[W+1]));
    check({tag, ".busy_in_done"}, 64'(busy), 64'd0);
    last_result = e[W-1:0];
    @(negedge clk);
    check({tag, ".done_pulse"}, 64'(done), 64'd0);
    check({tag, ".idle_after"}, 64'(busy), 64'd0);
    check({tag, ".result_after"}, 64'(result), 64'(e[W-1:0]));
  endtask

  initial begin
    logic [W-1:0] x, y;
    logic o;
    int saw_done;

    do_reset();
    check("reset.busy", 64'(busy), 64'd0);
    check("reset.done", 64'(done), 64'd0);
    check("reset.result", 64'(result), 64'd0);
    check("reset.cout", 64'(cout), 64'd0);
    check("reset.bcd_err", 64'(bcd_err), 64'd0);

    run_op("add_1234_5678", 16'h1234, 16'h5678, 1'b0, 1'b0, {1'b0, 1'b0, 16'h6912});
    run_op("add_9999_0001", 16'h9999, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h0000});
`ifdef BCD_SUB_EN
    run_op("sub_5000_1234", 16'h5000, 16'h1234, 1'b1, 1'b0, {1'b0, 1'b1, 16'h3766});
    run_op("sub_0123_0456", 16'h0123, 16'h0456, 1'b1, 1'b0, {1'b0, 1'b0, 16'h9667});
`else
    run_op("nosub_5000_1234", 16'h5000, 16'h1234, 1'b1, 1'b0, {1'b0, 1'b0, 16'h6234});
`endif
    run_op("err_00A0", 16'h00A0, 16'h0000, 1'b0, 1'b1, {1'b1, 1'b0, 16'h0100});

    // Abort an add in cycle 4 with reset, then confirm silence and a clean restart.
    @(negedge clk);
    start = 1'b1; a = 16'h1234; b = 16'h5678; op = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    check("rst_mid.busy", 64'(busy), 64'd0);
    check("rst_mid.done", 64'(done), 64'd0);
    check("rst_mid.result", 64'(result), 64'd0);
    check("rst_mid.cout", 64'(cout), 64'd0);
    check("rst_mid.bcd_err", 64'(bcd_err), 64'd0);
    rst = 1'b0; start = 1'b0;
    last_result = '0;
    saw_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) saw_done++;
    end
    check("rst_mid.no_done", 64'(saw_done), 64'd0);
    run_op("after_rst", 16'h0042, 16'h0058, 1'b0, 1'b0, {1'b0, 1'b0, 16'h0100});

    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < D; i++) begin
        x[i*4 +: 4] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                                   : 4'($urandom_range(0, 9));
        y[i*4 +: 4] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                                   : 4'($urandom_range(0, 9));
      end
      o = 1'($urandom_range(0, 1));
      run_op($sformatf("rand%0d", n), x, y, o, 1'($urandom_range(0, 1)),
             model(x, y, eff_op(o)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/bcd_serial_alu_ctrl.md
BCD_SERIAL_ALU_CTRL -- requirements
Module: bcd_serial_alu_ctrl

Interface
REQ-001 Parameter: DIGITS, default 4, number of BCD digits per operand (legal 1..8).
REQ-002 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: start  input  1  request a new operation; accepted only in IDLE.
REQ-005 Port: op  input  1  0 = add, 1 = subtract (a - b); sampled with start.
REQ-006 Port: a  input  4*DIGITS  BCD operand A, digit 0 in bits [3:0]; sampled with start.
REQ-007 Port: b  input  4*DIGITS  BCD operand B, same layout; sampled with start.
REQ-008 Port: busy  output  1  high while an accepted operation is in progress (ADD/CORR states).
REQ-009 Port: done  output  1  single-cycle pulse marking result/cout/bcd_err valid.
REQ-010 Port: result  output  4*DIGITS  BCD result; held between done pulses.
REQ-011 Port: cout  output  1  add: decimal carry out; sub: 1 = no borrow (a >= b).
REQ-012 Port: bcd_err  output  1  1 if any digit of latched a or b exceeded 9.

Function
REQ-013 The block SHALL instantiate exactly one four_bit_add as its sole arithmetic unit and time-share it across all digits and both phases.
REQ-014 FSM states SHALL be IDLE, ADD, CORR, DONE; reset state IDLE.
REQ-015 IDLE + start=1: latch a, b, op; digit index := 0; carry := op; bcd_err flag := any digit >9; go to ADD.
REQ-016 IDLE + start=0: stay in IDLE.
REQ-017 ADD: adder computes raw = a_d + b'_d + carry (5-bit incl. adder carry), where b'_d = b_d for add and (9 - b_d) mod 16 for sub; raw registered; go to CORR.
REQ-018 CORR: if raw > 9, adder computes raw[3:0] + 6, digit result := low nibble, carry := 1; else digit result := raw[3:0], carry := 0.
REQ-019 CORR with index < DIGITS-1: index += 1, go to ADD; with index = DIGITS-1: go to DONE.
REQ-020 DONE: copy internal result into result, carry into cout, flag into bcd_err; done=1 for this one cycle; next state IDLE unconditionally.
REQ-021 Latency: start accepted in cycle 0 -> busy=1 in cycles 1..2*DIGITS -> done=1 in cycle 2*DIGITS+1.
REQ-022 start while busy, or in the DONE cycle, SHALL be ignored (no re-latch, no queueing).
REQ-023 Subtract result with cout=0 SHALL be the ten's complement of (b - a) over DIGITS digits; no sign conversion.
REQ-024 Non-BCD input digits SHALL NOT stop the operation; arithmetic proceeds per REQ-017/018, and bcd_err reports them.
REQ-025 result, cout, bcd_err SHALL change only in the DONE cycle or on reset.

Reset
REQ-026 rst=1 at a clock edge SHALL force IDLE, busy=0, done=0, result=0, cout=0, bcd_err=0 and clear index, carry and internal registers.
REQ-027 rst mid-operation SHALL abort it with no done pulse; rst has priority over start in the same cycle.

Configuration
REQ-028 Macro BCD_SUB_EN: when defined, op selects add/subtract per REQ-005/017/023.
REQ-029 When BCD_SUB_EN is not defined, op SHALL be ignored, the nine's-complement path omitted, initial carry 0, and every operation an add.

Verification
REQ-030 DIGITS=4, add a=1234 b=5678 -> result 6912, cout 0, bcd_err 0, done exactly in cycle 9 after start.
REQ-031 Add a=9999 b=0001 -> result 0000, cout 1 (full carry ripple through all digits).
REQ-032 Sub a=5000 b=1234 -> result 3766, cout 1; sub a=0123 b=0456 -> result 9667, cout 0.
REQ-033 Add a=00A0 b=0000 -> done pulse, bcd_err 1; start pulsed in cycles 3 and 5 of the operation ignored, result unchanged until done.
REQ-034 rst in cycle 4 of an add -> no done, all outputs 0 next cycle; new start accepted the cycle after rst deasserts.
REQ-035 Without BCD_SUB_EN, op=1 a=5000 b=1234 -> result 6234, cout 0.
